// File: rtl/alu_seq_controller.sv
// Sequential ALU control: latches ALU_op on start, decodes datapath controls,
// and sequences the WIDTH-iteration shift-add multiplier for MUL_OP.
module alu_seq_controller #(
  parameter int              WIDTH  = 32,
  parameter int              OP_W   = 3,
  parameter logic [OP_W-1:0] MUL_OP = OP_W'(3'b101),
  parameter int              CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [OP_W-1:0]  ALU_op,
  input  logic             mul_lsb,
  output logic             bitwise,
  output logic             carry_in,
  output logic             mux_dec,
  output logic             busy,
  output logic             done,
  output logic             mul_load,
  output logic             mul_add,
  output logic             mul_shift,
  output logic [CNT_W-1:0] iter_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: start (with ALU_op) is accepted only while busy=0 and abort=0;
  // busy stays high until the one-cycle done pulse has been issued, and an
  // abort in LOAD/CALC returns to idle without any done.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [OP_W-1:0] op_q;
  logic            accept;
  logic            last_iter;
  logic            upper_zero;
  logic            bw_raw;

  assign accept    = (state == IDLE) && start && !abort;
  assign last_iter = (iter_cnt == CNT_W'(WIDTH - 1));
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      iter_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) op_q <= ALU_op;
      case (state)
        LOAD:    iter_cnt <= '0;
        CALC:    iter_cnt <= abort ? '0 : iter_cnt + CNT_W'(1);
        default: iter_cnt <= iter_cnt;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    mul_load  = 1'b0;
    mul_add   = 1'b0;
    mul_shift = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = (ALU_op == MUL_OP) ? LOAD : DONE;
      end
      LOAD: begin
        mul_load  = 1'b1;
        state_nxt = abort ? IDLE : CALC;
      end
      CALC: begin
        // Datapath still sees this cycle's shift/add even when aborting.
        mul_shift = 1'b1;
        mul_add   = mul_lsb;
        if (abort)          state_nxt = IDLE;
        else if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Any set bit above the 3-bit opcode field invalidates the decode.
  assign upper_zero = ((op_q >> 3) == '0);
  assign bw_raw     = op_q[2] & (op_q[1] | (~op_q[1] & ~op_q[0]));
  assign bitwise    = busy & upper_zero & bw_raw;
  assign carry_in   = busy & upper_zero & bw_raw;
  assign mux_dec    = busy & upper_zero & (&op_q[2:0]);

endmodule

// File: tb/tb_alu_seq_controller.sv
// Directed bench for alu_seq_controller (WIDTH=8): decode sweep, multiply
// sequencing, reset mid-multiply, abort cases and back-to-back operations.
module tb_alu_seq_controller;

  localparam int WIDTH = 8;
  localparam int OP_W  = 3;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk;
  logic             reset;
  logic             start;
  logic             abort;
  logic [OP_W-1:0]  ALU_op;
  logic             mul_lsb;
  logic             bitwise;
  logic             carry_in;
  logic             mux_dec;
  logic             busy;
  logic             done;
  logic             mul_load;
  logic             mul_add;
  logic             mul_shift;
  logic [CNT_W-1:0] iter_cnt;
  logic [1:0]       state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0] sweep_op [0:6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  logic       sweep_bw [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       sweep_mx [0:6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [7:0] exp_add_pat;
  logic [7:0] mreg;

  alu_seq_controller #(.WIDTH(WIDTH), .OP_W(OP_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .ALU_op    (ALU_op),
    .mul_lsb   (mul_lsb),
    .bitwise   (bitwise),
    .carry_in  (carry_in),
    .mux_dec   (mux_dec),
    .busy      (busy),
    .done      (done),
    .mul_load  (mul_load),
    .mul_add   (mul_add),
    .mul_shift (mul_shift),
    .iter_cnt  (iter_cnt),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; ALU_op = '0; mul_lsb = 1'b0;
    exp_add_pat = 8'b1011_0101;
    mreg        = 8'hB5;
    #12;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_bitwise", bitwise, 1'b0);
    chk1("rst_mul_load", mul_load, 1'b0);
    chkn("rst_iter", iter_cnt, 4'd0);
    reset = 1'b0;
    tick();

    // Multiply with mul_lsb from a multiplier-register model of 8'b1011_0101
    start = 1'b1; ALU_op = 3'b101;
    mul_lsb = mreg[0];
    tick();
    start = 1'b0;
    chk1("mul_c1_load", mul_load, 1'b1);
    chk1("mul_c1_no_shift", mul_shift, 1'b0);
    chk1("mul_c1_no_add", mul_add, 1'b0);
    chk1("mul_c1_busy", busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("mul_shift", mul_shift, 1'b1);
      chk1("mul_add", mul_add, exp_add_pat[i]);
      chk1("mul_calc_load", mul_load, 1'b0);
      chkn("mul_iter", iter_cnt, 4'(i));
      chk1("mul_calc_done", done, 1'b0);
      mreg    = mreg >> 1;
      mul_lsb = mreg[0];
    end
    tick();
    chk1("mul_c10_done", done, 1'b1);
    chk1("mul_c10_shift", mul_shift, 1'b0);
    chkn("mul_c10_iter", iter_cnt, 4'd8);
    tick();
    chk1("mul_idle_done", done, 1'b0);
    chk1("mul_idle_busy", busy, 1'b0);
    chkn("mul_idle_iter", iter_cnt, 4'd8);

    // Reset in CALC iteration 5
    mul_lsb = 1'b1;
    start = 1'b1; ALU_op = 3'b101;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chkn("rstmid_iter5", iter_cnt, 4'd5);
    chk1("rstmid_add_pre", mul_add, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk1("rstmid_busy", busy, 1'b0);
    chk1("rstmid_shift", mul_shift, 1'b0);
    chk1("rstmid_add", mul_add, 1'b0);
    chkn("rstmid_iter", iter_cnt, 4'd0);
    chk1("rstmid_done", done, 1'b0);
    #2 reset = 1'b0;
    mul_lsb = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk1("rstmid_no_done", done, 1'b0);
      chk1("rstmid_idle", busy, 1'b0);
    end
    start = 1'b1; ALU_op = 3'b110;
    tick();
    start = 1'b0;
    chk1("rstmid_110_done", done, 1'b1);
    chk1("rstmid_110_bitwise", bitwise, 1'b1);
    chk1("rstmid_110_carry", carry_in, 1'b1);
    chk1("rstmid_110_mux", mux_dec, 1'b0);
    tick();
    chk1("rstmid_110_end", busy, 1'b0);

    // Decode sweep over every non-multiply opcode
    for (int k = 0; k < 7; k++) begin
      start = 1'b1; ALU_op = sweep_op[k];
      tick();
      start = 1'b0;
      chk1("sweep_done", done, 1'b1);
      chk1("sweep_busy", busy, 1'b1);
      chk1("sweep_bitwise", bitwise, sweep_bw[k]);
      chk1("sweep_carry", carry_in, sweep_bw[k]);
      chk1("sweep_mux", mux_dec, sweep_mx[k]);
      tick();
      chk1("sweep_done_end", done, 1'b0);
      chk1("sweep_busy_end", busy, 1'b0);
      chk1("sweep_gated_bw", bitwise, 1'b0);
    end

    // start held high; ALU_op changed during CALC must not reach op_q
    start = 1'b1; ALU_op = 3'b101;
    tick();
    chk1("hold_load", mul_load, 1'b1);
    tick();
    chkn("hold_iter0", iter_cnt, 4'd0);
    ALU_op = 3'b111;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk1("hold_mux", mux_dec, 1'b0);
      chk1("hold_bitwise", bitwise, 1'b0);
      chk1("hold_no_load", mul_load, 1'b0);
    end
    ALU_op = 3'b101;
    tick();
    chk1("hold_done", done, 1'b1);
    tick();
    chk1("hold_idle", busy, 1'b0);
    chk1("hold_idle_load", mul_load, 1'b0);
    tick();
    chk1("hold_reload", mul_load, 1'b1);
    tick();
    chkn("hold2_iter0", iter_cnt, 4'd0);
    for (int i = 0; i < 3; i++) tick();
    chkn("hold2_iter3", iter_cnt, 4'd3);

    // Abort at CALC iteration 3 with start still high
    abort = 1'b1;
    chk1("abort_shift_driven", mul_shift, 1'b1);
    tick();
    chk1("abort_idle", busy, 1'b0);
    chk1("abort_no_done", done, 1'b0);
    chkn("abort_iter", iter_cnt, 4'd0);
    abort = 1'b0;
    tick();
    chk1("abort_restart", mul_load, 1'b1);
    start = 1'b0; abort = 1'b1;
    tick();
    chk1("abort_load_idle", busy, 1'b0);
    chk1("abort_load_no_done", done, 1'b0);

    // abort has priority over start in IDLE
    start = 1'b1; ALU_op = 3'b111;
    tick();
    chk1("abort_start_idle", busy, 1'b0);
    chk1("abort_start_no_done", done, 1'b0);
    abort = 1'b0;

    // abort in DONE does not suppress the pulse
    ALU_op = 3'b100;
    tick();
    start = 1'b0; abort = 1'b1;
    chk1("abort_done_pulse", done, 1'b1);
    chk1("abort_done_bitwise", bitwise, 1'b1);
    tick();
    chk1("abort_done_end", done, 1'b0);
    abort = 1'b0;

    // Back-to-back: 111 then 100, start also high during DONE
    start = 1'b1; ALU_op = 3'b111;
    tick();
    chk1("b2b_done1", done, 1'b1);
    chk1("b2b_mux1", mux_dec, 1'b1);
    ALU_op = 3'b100;
    tick();
    chk1("b2b_gap_done", done, 1'b0);
    chk1("b2b_gap_busy", busy, 1'b0);
    tick();
    start = 1'b0;
    chk1("b2b_done2", done, 1'b1);
    chk1("b2b_mux2", mux_dec, 1'b0);
    chk1("b2b_bitwise2", bitwise, 1'b1);
    tick();
    chk1("b2b_end", done, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
